ub_burst_ctrl: RTL
==================

Name: ub_burst_ctrl

Overview:
- Sequencer/arbiter in front of SRAM_UnifiedBuffer (single-port, synchronous, 1-cycle read latency).
- Shares the buffer between two requesters: the host loader (write bursts) and the systolic-array feeder (read bursts).
- Accepts burst commands (base address, beat count) and generates the SRAM write_enable/address/data_in sequence.
- Returns read data with a valid strobe and signals burst completion.

Parameters:
- ADDRESSSIZE, 10, SRAM address width; addresses wrap modulo 2^ADDRESSSIZE.
- WORDSIZE, 64, SRAM word width.
- LENSIZE, 8, burst length field width; len encodes beats-1, so max burst is 2^LENSIZE beats.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_cmd_valid  in  1  host write-burst request.
- wr_cmd_ready  out  1  write command accepted this cycle.
- wr_cmd_addr  in  ADDRESSSIZE  write burst base address.
- wr_cmd_len  in  LENSIZE  write beats-1.
- wr_data_valid  in  1  host write beat present.
- wr_data_ready  out  1  controller consumes the beat.
- wr_data  in  WORDSIZE  write beat payload.
- wr_done  out  1  1-cycle pulse; last write beat committed.
- rd_cmd_valid  in  1  feeder read-burst request.
- rd_cmd_ready  out  1  read command accepted this cycle.
- rd_cmd_addr  in  ADDRESSSIZE  read burst base address.
- rd_cmd_len  in  LENSIZE  read beats-1.
- rd_valid  out  1  rd_data is valid.
- rd_data  out  WORDSIZE  read beat; equals sram_data_out.
- rd_done  out  1  asserted together with the last rd_valid of a burst.
- busy  out  1  state != IDLE.
- sram_we  out  1  to SRAM write_enable.
- sram_addr  out  ADDRESSSIZE  to SRAM address.
- sram_wdata  out  WORDSIZE  to SRAM data_in.
- sram_data_out  in  WORDSIZE  from SRAM data_out.

Behaviour:
- Reset values (sync, held while rst=1): state IDLE, beat counter 0, last_grant=READ, and all of the following are 0: wr_cmd_ready, rd_cmd_ready, wr_data_ready, wr_done, rd_valid, rd_done, busy, sram_we, sram_addr.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready is combinational for the granted requester only.
  - Only one valid: grant it.
  - Both valid: grant the side opposite last_grant. After reset, write wins first.
  - On accept, latch base and len, clear the counter, update last_grant, and move to WRITE or READ next cycle.
  - No command is accepted outside IDLE.
- WRITE:
  - wr_data_ready=1.
  - sram_we = wr_data_valid (combinational).
  - sram_addr = base+cnt (mod 2^ADDRESSSIZE); sram_wdata = wr_data.
  - Counter advances only on valid&ready. A host stall (valid=0) holds the address and writes nothing.
  - On the beat where cnt==len: next state IDLE, wr_done pulses in the following cycle.
- READ:
  - sram_we=0, sram_addr = base+cnt, one address per cycle with no stalls. The feeder has no backpressure.
  - After cnt==len is issued, go to DRAIN.
- rd_valid is registered: high the cycle after each READ-state address issue. rd_data passes through from sram_data_out.
- DRAIN (1 cycle): presents the last beat with rd_valid=1 and rd_done=1, then returns to IDLE.
- Latency: a read command accepted in cycle T gives its first rd_valid at T+2 and its last at T+2+len.
- No idle cycle is inserted between bursts beyond the IDLE accept cycle.
- Outside WRITE, sram_we=0 and sram_wdata is don't-care (drive wr_data).
- Address wrap: base 1022, len 3 produces 1022, 1023, 0, 1. Wrap is silent.
- Reset mid-burst aborts the burst: no done pulse, rd_valid=0 from the next edge, SRAM contents already written remain.
- len=0 means a single-beat burst.

Optional Feature:
- Macro UB_CTRL_PERF_CNT_EN.
- When defined: adds outputs perf_wr_beats[31:0], perf_rd_beats[31:0] and perf_stall_cycles[31:0].
  - perf_wr_beats counts committed writes; perf_rd_beats counts rd_valid beats.
  - perf_stall_cycles counts cycles in WRITE with wr_data_valid=0.
  - All three are cleared by rst and saturate at all-ones.
- When not defined: those ports and the associated logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ub_pkg holds:
  - the state encoding enum (IDLE=0, WRITE=1, READ=2, DRAIN=3);
  - grant enum (GNT_WR=0, GNT_RD=1);
  - default ADDRESSSIZE/WORDSIZE/LENSIZE constants.
- One natural sub-module: ub_rr_arbiter, the 2-requester round-robin arbiter with last_grant register. Everything else stays in ub_burst_ctrl.

Test Plan:
- Write burst base 0, len 15 with 16 hex-file words, then read burst base 0, len 15 -> 16 rd_valid beats, data identical in order, rd_done on the 16th beat, wr_done one cycle after the 16th write.
- wr_cmd_valid and rd_cmd_valid both high out of reset -> write granted first; the next simultaneous pair -> read granted; strict alternation over 4 contested commands.
- Host drops wr_data_valid for 3 cycles mid-burst (base 100, len 7) -> no sram_we in those cycles; readback of 100..107 matches the 8 beats.
- Read base 1022, len 3 after writing 1022, 1023, 0, 1 -> sram_addr sequence 1022, 1023, 0, 1; correct data, no error.
- rst asserted at beat 5 of a 16-beat read -> rd_valid=0 the next cycle, no rd_done, busy=0; a new command is accepted two cycles after rst deasserts.
- len=0 read at addr 7 -> exactly one rd_valid with rd_done, first data at T+2. With UB_CTRL_PERF_CNT_EN, perf_rd_beats increments by 1.

Source files
------------

// File: rtl/ub_pkg.sv
// Shared types and default widths for the unified-buffer burst controller.
package ub_pkg;

   localparam int UB_ADDRESSSIZE = 10;
   localparam int UB_WORDSIZE    = 64;
   localparam int UB_LENSIZE     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } ub_state_e;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } ub_gnt_e;

endpackage

// File: rtl/ub_rr_arbiter.sv
// Two-requester round-robin arbiter: on contention the side opposite the last grant wins.
module ub_rr_arbiter
   import ub_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic req_wr_i,
   input  logic req_rd_i,
   output logic gnt_wr_o,
   output logic gnt_rd_o
);

   ub_gnt_e last_q, last_d;

   always_comb begin
      gnt_wr_o = en_i & req_wr_i & (~req_rd_i | (last_q == GNT_RD));
      gnt_rd_o = en_i & req_rd_i & (~req_wr_i | (last_q == GNT_WR));
      last_d   = last_q;
      if (gnt_wr_o) begin
         last_d = GNT_WR;
      end else if (gnt_rd_o) begin
         last_d = GNT_RD;
      end
   end

   // Reset to GNT_RD so the write side wins the first contested cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= GNT_RD;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/ub_burst_ctrl.sv
// Burst sequencer sharing a single-port SRAM between host write bursts and feeder read bursts.
// Optional performance counters are enabled by defining UB_CTRL_PERF_CNT_EN.
module ub_burst_ctrl
   import ub_pkg::*;
#(
   parameter int ADDRESSSIZE = UB_ADDRESSSIZE,
   parameter int WORDSIZE    = UB_WORDSIZE,
   parameter int LENSIZE     = UB_LENSIZE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_cmd_valid,
   output logic                   wr_cmd_ready,
   input  logic [ADDRESSSIZE-1:0] wr_cmd_addr,
   input  logic [LENSIZE-1:0]     wr_cmd_len,
   input  logic                   wr_data_valid,
   output logic                   wr_data_ready,
   input  logic [WORDSIZE-1:0]    wr_data,
   output logic                   wr_done,
   input  logic                   rd_cmd_valid,
   output logic                   rd_cmd_ready,
   input  logic [ADDRESSSIZE-1:0] rd_cmd_addr,
   input  logic [LENSIZE-1:0]     rd_cmd_len,
   output logic                   rd_valid,
   output logic [WORDSIZE-1:0]    rd_data,
   output logic                   rd_done,
   output logic                   busy,
   output logic                   sram_we,
   output logic [ADDRESSSIZE-1:0] sram_addr,
   output logic [WORDSIZE-1:0]    sram_wdata,
   input  logic [WORDSIZE-1:0]    sram_data_out
`ifdef UB_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]            perf_wr_beats,
   output logic [31:0]            perf_rd_beats,
   output logic [31:0]            perf_stall_cycles
`endif
);

   ub_state_e              state_q, state_d;
   logic [ADDRESSSIZE-1:0] base_q, base_d;
   logic [LENSIZE-1:0]     len_q, len_d;
   logic [LENSIZE-1:0]     cnt_q, cnt_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   rd_done_q, rd_done_d;
   logic                   wr_done_q, wr_done_d;
   logic [ADDRESSSIZE-1:0] cur_addr;
   logic                   gnt_wr, gnt_rd;

   ub_rr_arbiter u_arb (
      .clk      (clk),
      .rst      (rst),
      .en_i     ((state_q == IDLE) & ~rst),
      .req_wr_i (wr_cmd_valid),
      .req_rd_i (rd_cmd_valid),
      .gnt_wr_o (gnt_wr),
      .gnt_rd_o (gnt_rd)
   );

   // Natural truncation of the sum gives the silent modulo-2^ADDRESSSIZE wrap.
   assign cur_addr = base_q + ADDRESSSIZE'(cnt_q);

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      rd_valid_d    = 1'b0;
      rd_done_d     = 1'b0;
      wr_done_d     = 1'b0;
      wr_data_ready = 1'b0;
      sram_we       = 1'b0;
      sram_addr     = '0;
      case (state_q)
         IDLE: begin
            if (gnt_wr) begin
               base_d  = wr_cmd_addr;
               len_d   = wr_cmd_len;
               cnt_d   = '0;
               state_d = WRITE;
            end else if (gnt_rd) begin
               base_d  = rd_cmd_addr;
               len_d   = rd_cmd_len;
               cnt_d   = '0;
               state_d = READ;
            end
         end
         WRITE: begin
            wr_data_ready = ~rst;
            sram_we       = wr_data_valid & ~rst;
            sram_addr     = cur_addr;
            if (wr_data_valid) begin
               if (cnt_q == len_q) begin
                  state_d   = IDLE;
                  wr_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         READ: begin
            sram_addr  = cur_addr;
            rd_valid_d = 1'b1;
            if (cnt_q == len_q) begin
               state_d   = DRAIN;
               rd_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_done_q  <= 1'b0;
         wr_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         rd_valid_q <= rd_valid_d;
         rd_done_q  <= rd_done_d;
         wr_done_q  <= wr_done_d;
      end
   end

   assign wr_cmd_ready = gnt_wr;
   assign rd_cmd_ready = gnt_rd;
   assign wr_done      = wr_done_q;
   assign rd_valid     = rd_valid_q;
   assign rd_done      = rd_done_q;
   assign rd_data      = sram_data_out;
   assign sram_wdata   = wr_data;
   assign busy         = (state_q != IDLE);

`ifdef UB_CTRL_PERF_CNT_EN
   logic [31:0] perf_wr_q, perf_rd_q, perf_stall_q;

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_wr_q    <= '0;
         perf_rd_q    <= '0;
         perf_stall_q <= '0;
      end else begin
         if (sram_we && (perf_wr_q != '1)) perf_wr_q <= perf_wr_q + 1'b1;
         if (rd_valid_q && (perf_rd_q != '1)) perf_rd_q <= perf_rd_q + 1'b1;
         if ((state_q == WRITE) && !wr_data_valid && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 1'b1;
         end
      end
   end

   assign perf_wr_beats     = perf_wr_q;
   assign perf_rd_beats     = perf_rd_q;
   assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
